// File: rtl/inst_sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// inst_sram_responder_pkg
// Shared constants for the instruction-side SRAM responder.
//   INST_SRAM_RESP_OUTSTANDING : default depth of in-flight fetch tracking
//   PC_WIDTH / INST_WIDTH      : fetch address and instruction widths
//   ptr_width()                : FIFO pointer width (at least 1 bit)
// ---------------------------------------------------------------------------
package inst_sram_responder_pkg;

    localparam int PC_WIDTH                   = 32;
    localparam int INST_WIDTH                 = 32;
    localparam int INST_SRAM_RESP_OUTSTANDING = 2;

    // A depth-1 FIFO still needs a 1-bit pointer; it simply never leaves 0.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : inst_sram_responder_pkg

// File: rtl/inst_sram_responder_if.sv
// ---------------------------------------------------------------------------
// inst_sram_if
// SRAM-like instruction fetch handshake between the fetch stages (master)
// and the responder (slave).
//   req     : fetch request valid                (master -> slave)
//   addr    : fetch address                      (master -> slave)
//   addr_ok : request accepted this cycle        (slave -> master)
//   data_ok : one-cycle pulse, rdata valid       (slave -> master)
//   rdata   : instruction word                   (slave -> master)
// ---------------------------------------------------------------------------
interface inst_sram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input addr_ok, input data_ok, input rdata);
    modport slave  (input req, input addr, output addr_ok, output data_ok, output rdata);
endinterface : inst_sram_if

// File: rtl/inst_sram_responder_cancel_tag_fifo.sv
// ---------------------------------------------------------------------------
// cancel_tag_fifo
// DEPTH-entry FIFO of 1-bit cancel tags, one per in-flight fetch.
//   clk, rst : clock, asynchronous active-high reset
//   push_i   : write tag_i at the tail (ignored when full)
//   tag_i    : cancel bit of the entry being pushed
//   pop_i    : drop the head entry (ignored when empty)
//   flush_i  : mark every stored entry cancelled
//   empty_o  : no entries held
//   full_o   : DEPTH entries held
//   head_o   : cancel bit of the oldest entry
// ---------------------------------------------------------------------------
module cancel_tag_fifo
    import inst_sram_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic tag_i,
    input  logic pop_i,
    input  logic flush_i,
    output logic empty_o,
    output logic full_o,
    output logic head_o
);
    localparam int               PTR_W = ptr_width(DEPTH);
    localparam int               CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0] tags_q, tags_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = tags_q[rd_ptr_q];

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Setting free slots too is harmless: a push always overwrites its slot.
        if (flush_i) tags_d = '1;
        if (do_push) begin
            tags_d[wr_ptr_q] = tag_i;
            wr_ptr_d         = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the tag storage is reset along with the pointers; a stale cancel bit must never outlive a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
            tags_q   <= tags_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : cancel_tag_fifo

// File: rtl/inst_sram_responder.sv
// ---------------------------------------------------------------------------
// inst_sram_responder
// Slave end of the instruction fetch interface. Each accepted fetch becomes
// one single-beat read (AR then R); results return as one-cycle data_ok
// pulses. Fetches issued before an exception flush are drained silently.
//   clk, rst         : clock, asynchronous active-high reset
//   inst_sram        : fetch handshake (slave modport)
//   excep_flush_i    : pipeline flush, cancels every in-flight fetch
//   arvalid_o/araddr_o/arready_i : read address channel
//   rvalid_i/rdata_i/rready_o    : read data channel (in order, never stalled)
// ---------------------------------------------------------------------------
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int OUTSTANDING = INST_SRAM_RESP_OUTSTANDING,
    parameter int ADDR_W      = PC_WIDTH,
    parameter int DATA_W      = INST_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    inst_sram_if.slave        inst_sram,
    input  logic              excep_flush_i,
    output logic              arvalid_o,
    output logic [ADDR_W-1:0] araddr_o,
    input  logic              arready_i,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              rready_o
);
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              push, pop;
    logic              fifo_empty, fifo_full, cancel_head;

    // Outputs are gated by rst so they read 0 while reset is held, even
    // though the fetch side may still be asserting req.
    assign inst_sram.addr_ok = !rst && inst_sram.req && (cnt_q < CNT_W'(OUTSTANDING)) && !ar_valid_q;
    assign inst_sram.data_ok = !rst && rvalid_i && !fifo_empty && !cancel_head && !excep_flush_i;
    assign inst_sram.rdata   = rst ? '0 : rdata_i;
    assign arvalid_o         = ar_valid_q;
    assign araddr_o          = araddr_q;
    assign rready_o          = 1'b1;

    assign push = inst_sram.addr_ok;
    // A beat with nothing outstanding is a protocol error and is ignored.
    assign pop  = rvalid_i && (cnt_q != '0);

    always_comb begin
        ar_valid_d = ar_valid_q;
        araddr_d   = araddr_q;
        // push only happens with ar_valid_q low, so the two never collide.
        if (push) begin
            ar_valid_d = 1'b1;
            araddr_d   = inst_sram.addr;
        end else if (ar_valid_q && arready_i) begin
            ar_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            ar_valid_q <= 1'b0;
            araddr_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ar_valid_q <= ar_valid_d;
            araddr_q   <= araddr_d;
        end
    end

    // A fetch accepted in the flush cycle carries a stale PC: tag it cancelled.
    cancel_tag_fifo #(.DEPTH(OUTSTANDING)) u_cancel_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .tag_i   (excep_flush_i),
        .pop_i   (pop),
        .flush_i (excep_flush_i),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .head_o  (cancel_head)
    );

    a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (rst) !(rvalid_i && cnt_q == '0));
    a_cnt_tracks_fifo  : assert property (@(posedge clk) disable iff (rst)
                                          (cnt_q == CNT_W'(OUTSTANDING)) == fifo_full);

endmodule : inst_sram_responder

// File: tb/tb_inst_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_inst_sram_responder
// Directed bench for inst_sram_responder (OUTSTANDING=2). Inputs change 1ns
// after each rising edge; outputs are sampled 3-4ns later, mid-cycle.
// The memory side returns 0x0280_0000 | addr[15:0] for each fetch.
// ---------------------------------------------------------------------------
module tb_inst_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        excep_flush = 1'b0;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        rready;

    int vectors     = 0;
    int miscompares = 0;

    inst_sram_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_sram_responder #(.OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_sram     (bus),
        .excep_flush_i (excep_flush),
        .arvalid_o     (arvalid),
        .araddr_o      (araddr),
        .arready_i     (arready),
        .rvalid_i      (rvalid),
        .rdata_i       (rdata),
        .rready_o      (rready)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        bus.req = 1'b1; bus.addr = 32'h1c00_0000; rdata = 32'hffff_ffff;
        #3;
        vectors++; if (bus.addr_ok !== 1'b0) begin miscompares++; $display("FAIL rst_addr_ok: got %b want 0", bus.addr_ok); end
        vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL rst_data_ok: got %b want 0", bus.data_ok); end
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
        vectors++; if (rready !== 1'b1) begin miscompares++; $display("FAIL rst_rready: got %b want 1", rready); end
        next_cycle(); next_cycle();
        bus.req = 1'b0; rdata = '0; rst = 1'b0;
        settle();
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rel_arvalid: got %b want 0", arvalid); end
        vectors++; if (araddr !== 32'h0) begin miscompares++; $display("FAIL rst_rel_araddr: got %h want 0", araddr); end
        next_cycle();
    endtask

    task automatic test_single_fetch(input string tag);
        bus.req = 1'b1; bus.addr = 32'h1c00_0000; arready = 1'b1;
        settle();
        vectors++; if (bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL %s_c0_addr_ok: got %b want 1", tag, bus.addr_ok); end
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL %s_c0_arvalid: got %b want 0", tag, arvalid); end
        next_cycle();
        bus.req = 1'b0;
        settle();
        vectors++; if (arvalid !== 1'b1) begin miscompares++; $display("FAIL %s_c1_arvalid: got %b want 1", tag, arvalid); end
        vectors++; if (araddr !== 32'h1c00_0000) begin miscompares++; $display("FAIL %s_c1_araddr: got %h want 1c000000", tag, araddr); end
        vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL %s_c1_data_ok: got %b want 0", tag, bus.data_ok); end
        next_cycle();
        rvalid = 1'b1; rdata = 32'h0280_0000;
        settle();
        vectors++; if (bus.data_ok !== 1'b1) begin miscompares++; $display("FAIL %s_c2_data_ok: got %b want 1", tag, bus.data_ok); end
        vectors++; if (bus.rdata !== 32'h0280_0000) begin miscompares++; $display("FAIL %s_c2_rdata: got %h want 02800000", tag, bus.rdata); end
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL %s_c2_arvalid: got %b want 0", tag, arvalid); end
        next_cycle();
        rvalid = 1'b0;
        settle();
        vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL %s_c3_data_ok: got %b want 0", tag, bus.data_ok); end
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("FAIL %s_c3_cnt: got %0d want 0", tag, dut.cnt_q); end
        next_cycle();
    endtask

    task automatic test_outstanding_limit();
        bus.req = 1'b1; bus.addr = 32'h1c00_0000;
        settle();
        vectors++; if (bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL lim_acc0: got %b want 1", bus.addr_ok); end
        next_cycle();
        bus.addr = 32'h1c00_0004;
        settle();
        vectors++; if (bus.addr_ok !== 1'b0) begin miscompares++; $display("FAIL lim_ar_busy0: got %b want 0", bus.addr_ok); end
        vectors++; if (araddr !== 32'h1c00_0000) begin miscompares++; $display("FAIL lim_araddr0: got %h want 1c000000", araddr); end
        next_cycle();
        settle();
        vectors++; if (bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL lim_acc1: got %b want 1", bus.addr_ok); end
        next_cycle();
        bus.addr = 32'h1c00_0008;
        settle();
        vectors++; if (araddr !== 32'h1c00_0004) begin miscompares++; $display("FAIL lim_araddr1: got %h want 1c000004", araddr); end
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            settle();
            vectors++; if (bus.addr_ok !== 1'b0) begin miscompares++; $display("FAIL lim_full_addr_ok[%0d]: got %b want 0", i, bus.addr_ok); end
            vectors++; if (dut.cnt_q !== 2'd2) begin miscompares++; $display("FAIL lim_full_cnt[%0d]: got %0d want 2", i, dut.cnt_q); end
            next_cycle();
        end
        rvalid = 1'b1; rdata = 32'h0280_0000;
        settle();
        vectors++; if (bus.data_ok !== 1'b1) begin miscompares++; $display("FAIL lim_d0_ok: got %b want 1", bus.data_ok); end
        vectors++; if (bus.rdata !== 32'h0280_0000) begin miscompares++; $display("FAIL lim_d0: got %h want 02800000", bus.rdata); end
        vectors++; if (bus.addr_ok !== 1'b0) begin miscompares++; $display("FAIL lim_pop_cycle_addr_ok: got %b want 0", bus.addr_ok); end
        next_cycle();
        rvalid = 1'b0;
        settle();
        vectors++; if (bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL lim_acc2: got %b want 1", bus.addr_ok); end
        next_cycle();
        bus.req = 1'b0;
        settle();
        vectors++; if (araddr !== 32'h1c00_0008) begin miscompares++; $display("FAIL lim_araddr2: got %h want 1c000008", araddr); end
        next_cycle();
        rvalid = 1'b1; rdata = 32'h0280_0004;
        settle();
        vectors++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h0280_0004) begin miscompares++; $display("FAIL lim_d1: got ok=%b %h want ok=1 02800004", bus.data_ok, bus.rdata); end
        next_cycle();
        rdata = 32'h0280_0008;
        settle();
        vectors++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h0280_0008) begin miscompares++; $display("FAIL lim_d2: got ok=%b %h want ok=1 02800008", bus.data_ok, bus.rdata); end
        next_cycle();
        rvalid = 1'b0;
        settle();
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("FAIL lim_cnt_end: got %0d want 0", dut.cnt_q); end
        next_cycle();
    endtask

    task automatic test_flush_drain();
        bus.req = 1'b1; bus.addr = 32'h1c00_0000;
        next_cycle();
        bus.addr = 32'h1c00_0004;
        next_cycle();
        next_cycle();
        bus.req = 1'b0;
        next_cycle();
        excep_flush = 1'b1;
        settle();
        vectors++; if (dut.cnt_q !== 2'd2) begin miscompares++; $display("FAIL fl_cnt_pre: got %0d want 2", dut.cnt_q); end
        next_cycle();
        excep_flush = 1'b0; bus.req = 1'b1; bus.addr = 32'h1c00_0100;
        rvalid = 1'b1; rdata = 32'h0280_0000;
        settle();
        vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL fl_old0_data_ok: got %b want 0", bus.data_ok); end
        vectors++; if (bus.addr_ok !== 1'b0) begin miscompares++; $display("FAIL fl_full_addr_ok: got %b want 0", bus.addr_ok); end
        next_cycle();
        rdata = 32'h0280_0004;
        settle();
        vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL fl_old1_data_ok: got %b want 0", bus.data_ok); end
        vectors++; if (bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL fl_new_addr_ok: got %b want 1", bus.addr_ok); end
        next_cycle();
        bus.req = 1'b0; rvalid = 1'b0;
        settle();
        vectors++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_0100) begin miscompares++; $display("FAIL fl_new_ar: got v=%b %h want v=1 1c000100", arvalid, araddr); end
        next_cycle();
        rvalid = 1'b1; rdata = 32'h0280_0100;
        settle();
        vectors++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h0280_0100) begin miscompares++; $display("FAIL fl_new_data: got ok=%b %h want ok=1 02800100", bus.data_ok, bus.rdata); end
        next_cycle();
        rvalid = 1'b0;
        settle();
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("FAIL fl_cnt_end: got %0d want 0", dut.cnt_q); end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        // flush coinciding with the R beat
        bus.req = 1'b1; bus.addr = 32'h1c00_0000;
        next_cycle();
        bus.req = 1'b0;
        next_cycle();
        rvalid = 1'b1; rdata = 32'h0280_0000; excep_flush = 1'b1;
        settle();
        vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL sim_rv_flush_data_ok: got %b want 0", bus.data_ok); end
        next_cycle();
        rvalid = 1'b0; excep_flush = 1'b0;
        settle();
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("FAIL sim_rv_flush_cnt: got %0d want 0", dut.cnt_q); end
        next_cycle();
        // flush coinciding with acceptance
        bus.req = 1'b1; bus.addr = 32'h1c00_0020; excep_flush = 1'b1;
        settle();
        vectors++; if (bus.addr_ok !== 1'b1) begin miscompares++; $display("FAIL sim_acc_flush_addr_ok: got %b want 1", bus.addr_ok); end
        next_cycle();
        bus.req = 1'b0; excep_flush = 1'b0;
        next_cycle();
        rvalid = 1'b1; rdata = 32'h0280_0020;
        settle();
        vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL sim_acc_flush_data_ok: got %b want 0", bus.data_ok); end
        next_cycle();
        rvalid = 1'b0;
        settle();
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("FAIL sim_acc_flush_cnt: got %0d want 0", dut.cnt_q); end
        next_cycle();
    endtask

    task automatic test_ar_stall();
        bus.req = 1'b1; bus.addr = 32'h1c00_0000; arready = 1'b0;
        next_cycle();
        bus.addr = 32'h1c00_0004;
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_0000) begin miscompares++; $display("FAIL stall_ar[%0d]: got v=%b %h want v=1 1c000000", i, arvalid, araddr); end
            vectors++; if (bus.addr_ok !== 1'b0) begin miscompares++; $display("FAIL stall_addr_ok[%0d]: got %b want 0", i, bus.addr_ok); end
            next_cycle();
        end
        arready = 1'b1;
        settle();
        vectors++; if (arvalid !== 1'b1 || bus.addr_ok !== 1'b0) begin miscompares++; $display("FAIL stall_hs: got v=%b ok=%b want v=1 ok=0", arvalid, bus.addr_ok); end
        next_cycle();
        settle();
        vectors++; if (bus.addr_ok !== 1'b1 || arvalid !== 1'b0) begin miscompares++; $display("FAIL stall_next_acc: got ok=%b v=%b want ok=1 v=0", bus.addr_ok, arvalid); end
        next_cycle();
        bus.req = 1'b0;
        next_cycle();
        rvalid = 1'b1; rdata = 32'h0280_0000;
        settle();
        vectors++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h0280_0000) begin miscompares++; $display("FAIL stall_d0: got ok=%b %h want ok=1 02800000", bus.data_ok, bus.rdata); end
        next_cycle();
        rdata = 32'h0280_0004;
        settle();
        vectors++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h0280_0004) begin miscompares++; $display("FAIL stall_d1: got ok=%b %h want ok=1 02800004", bus.data_ok, bus.rdata); end
        next_cycle();
        rvalid = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_flight();
        bus.req = 1'b1; bus.addr = 32'h1c00_0000; arready = 1'b1;
        next_cycle();
        bus.addr = 32'h1c00_0004;
        next_cycle();
        next_cycle();
        arready = 1'b0; bus.addr = 32'h1c00_0008; rvalid = 1'b1; rdata = 32'h0280_0000;
        #1;
        vectors++; if (dut.cnt_q !== 2'd2 || bus.data_ok !== 1'b1) begin miscompares++; $display("FAIL rmf_pre: got cnt=%0d ok=%b want cnt=2 ok=1", dut.cnt_q, bus.data_ok); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.data_ok !== 1'b0) begin miscompares++; $display("FAIL rmf_data_ok: got %b want 0", bus.data_ok); end
        vectors++; if (arvalid !== 1'b0) begin miscompares++; $display("FAIL rmf_arvalid: got %b want 0", arvalid); end
        vectors++; if (bus.addr_ok !== 1'b0) begin miscompares++; $display("FAIL rmf_addr_ok: got %b want 0", bus.addr_ok); end
        vectors++; if (dut.cnt_q !== 2'd0) begin miscompares++; $display("FAIL rmf_cnt: got %0d want 0", dut.cnt_q); end
        vectors++; if (rready !== 1'b1) begin miscompares++; $display("FAIL rmf_rready: got %b want 1", rready); end
        rvalid = 1'b0; bus.req = 1'b0; arready = 1'b1; rdata = '0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        test_single_fetch("rmf_fetch");
    endtask

    initial begin
        bus.req = 1'b0; bus.addr = '0;
        test_reset();
        test_single_fetch("single");
        test_outstanding_limit();
        test_flush_drain();
        test_simultaneous();
        test_ar_stall();
        test_reset_mid_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_inst_sram_responder

// File: doc/inst_sram_responder.md
Name: inst_sram_responder

Overview:
- Responder (slave) end of the instruction-side SRAM-like fetch interface. The fetch stages drive req/addr and consume addr_ok/data_ok/rdata.
- Converts accepted fetch requests into single-beat AXI-style reads toward the instruction bus/memory.
- Returns each result as a one-cycle data_ok pulse.
- Tracks up to OUTSTANDING requests in flight. Any request issued before an exception flush is drained silently, so a stale instruction never produces data_ok after the flush.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered requests; power of two, 1..8.
- ADDR_W, 32, fetch address width; matches `PcWidth.
- DATA_W, 32, instruction width; matches `InstWidth.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_sram_req_i  in  1  fetch request valid.
- inst_sram_addr_i  in  ADDR_W  fetch address; passed through unchecked (fetch side handles ADEF and suppresses req).
- inst_sram_addr_ok_o  out  1  request accepted this cycle.
- inst_sram_data_ok_o  out  1  one-cycle pulse: rdata valid for oldest live request.
- inst_sram_rdata_o  out  DATA_W  instruction word.
- excep_flush_i  in  1  pipeline flush; cancels every in-flight request.
- arvalid_o  out  1  read address valid.
- araddr_o  out  ADDR_W  read address.
- arready_i  in  1  read address accepted.
- rvalid_i  in  1  read data valid; in-order, one beat per AR.
- rdata_i  in  DATA_W  read data.
- rready_o  out  1  tied 1; responder never back-pressures R.

Behaviour:
Reset:
- Asynchronous rst clears the following immediately and holds them clear while rst=1: cnt, ar_valid_q, araddr_q, tag FIFO pointers and cancel bits.
- All outputs read 0 during reset (rdata_o is don't-care, gated to 0), except rready_o=1.
- Reset mid-transaction drops all tracking; the system resets the memory side together with this block.

Address phase:
- addr_ok_o = req_i && (cnt < OUTSTANDING) && !ar_valid_q.
- On addr_ok_o:
  - ar_valid_q<=1 and araddr_q<=addr_i.
  - Push cancel tag = excep_flush_i. A request accepted in the flush cycle carries a stale PC and is cancelled.
  - cnt increments.
- arvalid_o=ar_valid_q and araddr_o=araddr_q; both stay stable until arready_i. ar_valid_q clears on arvalid_o&&arready_i.
- Minimum latency: addr_ok in cycle 0, arvalid in cycle 1, data_ok in the same cycle rvalid_i arrives (cycle 2 at the earliest).

Data phase:
- data_ok_o = rvalid_i && !cancel_head && !excep_flush_i; rdata_o = rdata_i, combinational.
- Every rvalid_i beat pops the tag FIFO and decrements cnt, whether cancelled or not.
- A flush in the same cycle as rvalid_i suppresses that data_ok.

Flush:
- In the excep_flush_i cycle, every valid FIFO entry's cancel bit is set to 1; the pushed entry is cancelled as above.
- A pending ar_valid_q is NOT withdrawn; its beat drains cancelled.
- New requests after the flush cycle are live. They may be accepted while cancelled beats are still draining, subject to the cnt limit.

Counter / width rules:
- cnt is $clog2(OUTSTANDING)+1 bits. FIFO pointers are $clog2(OUTSTANDING) bits and wrap modulo OUTSTANDING.
- Push and pop in the same cycle leave cnt unchanged. This is legal at cnt==OUTSTANDING only if addr_ok was granted, which it is not (full blocks addr_ok).
- rvalid_i with cnt==0 is a protocol error. It is ignored, cnt does not underflow, and the condition is flagged by a simulation assertion.

State machine: no explicit FSM. The state is {ar_valid_q, cnt, FIFO}.

Decomposition:
- Add to the shared define header `InstSramRespOutstanding` and bus widths for the responder interface next to the existing `PcWidth / `InstWidth.
- One sub-module: cancel_tag_fifo, a DEPTH-entry 1-bit FIFO with push, pop and flush-all-set ports, plus empty/full outputs and head output.

Test Plan:
1. Single fetch: req addr 0x1c000000, arready=1, rvalid two cycles later with rdata 0x02800000 -> addr_ok in cycle 0, arvalid/araddr=0x1c000000 in cycle 1, data_ok=1 for exactly one cycle with rdata 0x02800000.
2. Outstanding limit: three back-to-back reqs (0x1c000000/04/08), arready=1, rvalid delayed 5 cycles -> first two accepted, third held with addr_ok=0 until the first rvalid pops; data order 0x..00, 0x..04, 0x..08.
3. Flush drain: two in flight, excep_flush_i pulse, then req 0x1c000100 -> both old beats give data_ok=0, new request returns data_ok=1 with its rdata, cnt returns to 0.
4. Simultaneous events: flush in the same cycle as rvalid -> data_ok=0. Flush in the same cycle as addr_ok -> that request's beat later gives data_ok=0.
5. AR stall: arready=0 for 3 cycles -> arvalid/araddr stable, addr_ok=0 for the next req, accepted in the cycle after arready handshake.
6. Reset mid-flight: rst asserted with cnt=2 -> data_ok/arvalid/addr_ok 0 immediately (asynchronous). After release, fresh fetch 0x1c000000 completes normally.
